// File: rtl/risc_data_path.sv
// Multi-cycle 32-bit RISC core: control FSM, 16x32 register file (R15 = PC), ALU and
// a 512-byte unified big-endian RAM. Program/data are preloaded through ram.memory.

module risc_ram (
    input  logic        clk_i,
    input  logic [8:0]  addr_i,
    output logic [31:0] rdata_o,
    input  logic        we_word_i,
    input  logic        we_byte_i,
    input  logic [31:0] wdata_i
);
    logic [7:0] memory [0:511];
    logic [8:0] addr1, addr2, addr3;

    // 9-bit adds make word accesses near the top wrap back to byte 0.
    assign addr1   = addr_i + 9'd1;
    assign addr2   = addr_i + 9'd2;
    assign addr3   = addr_i + 9'd3;
    assign rdata_o = {memory[addr_i], memory[addr1], memory[addr2], memory[addr3]};

    always_ff @(posedge clk_i) begin
        if (we_word_i) begin
            memory[addr_i] <= wdata_i[31:24];
            memory[addr1]  <= wdata_i[23:16];
            memory[addr2]  <= wdata_i[15:8];
            memory[addr3]  <= wdata_i[7:0];
        end else if (we_byte_i) begin
            memory[addr_i] <= wdata_i[7:0];
        end
    end
endmodule

module risc_register_file (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  rn_addr_i,
    input  logic [3:0]  rm_addr_i,
    input  logic [3:0]  rd_addr_i,
    output logic [31:0] rn_data_o,
    output logic [31:0] rm_data_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] pc_o,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] reg_to_mult [0:15];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 16; i++) begin
                reg_to_mult[i] <= '0;
            end
        end else if (we_i) begin
            reg_to_mult[waddr_i] <= wdata_i;
        end
    end

    assign rn_data_o = reg_to_mult[rn_addr_i];
    assign rm_data_o = reg_to_mult[rm_addr_i];
    assign rd_data_o = reg_to_mult[rd_addr_i];
    assign pc_o      = reg_to_mult[15];
endmodule

module risc_data_path (
    input  logic       main_clk,
    input  logic       reset,
    output logic [9:0] current_state
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_MOVI,
        OP_ADDI, OP_LDR, OP_STR, OP_LDRB, OP_STRB, OP_B, OP_BZ, OP_HALT
    } opcode_e;

    state_e      state_q;
    logic [31:0] ir_q, alu_q, mdr_q;
    logic [31:0] alu_out;
    logic [31:0] rn_data, rm_data, rd_data, pc;
    logic [31:0] simm, mem_rdata;
    logic [8:0]  mem_addr;
    opcode_e     op;
    logic        is_load, is_branch, branch_taken;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign op           = opcode_e'(ir_q[31:28]);
    assign simm         = {{16{ir_q[15]}}, ir_q[15:0]};
    assign is_load      = (op == OP_LDR) || (op == OP_LDRB);
    assign is_branch    = (op == OP_B) || (op == OP_BZ);
    assign branch_taken = (op == OP_B) || ((op == OP_BZ) && (rd_data == '0));
    assign mem_addr     = (state_q == S_FETCH) ? pc[8:0] : alu_q[8:0];
    assign current_state = {7'd0, state_q};

    risc_register_file register_file (
        .clk_i     (main_clk),
        .rst_ni    (reset),
        .rn_addr_i (ir_q[23:20]),
        .rm_addr_i (ir_q[19:16]),
        .rd_addr_i (ir_q[27:24]),
        .rn_data_o (rn_data),
        .rm_data_o (rm_data),
        .rd_data_o (rd_data),
        .pc_o      (pc),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    risc_ram ram (
        .clk_i     (main_clk),
        .addr_i    (mem_addr),
        .rdata_o   (mem_rdata),
        .we_word_i ((state_q == S_MEM) && (op == OP_STR)),
        .we_byte_i ((state_q == S_MEM) && (op == OP_STRB)),
        .wdata_i   (rd_data)
    );

    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = rn_data + rm_data;
            OP_SUB:  alu_out = rn_data - rm_data;
            OP_AND:  alu_out = rn_data & rm_data;
            OP_ORR:  alu_out = rn_data | rm_data;
            OP_EOR:  alu_out = rn_data ^ rm_data;
            OP_MOV:  alu_out = rm_data;
            OP_MOVI: alu_out = {16'd0, ir_q[15:0]};
            OP_ADDI, OP_LDR, OP_STR, OP_LDRB, OP_STRB: alu_out = rn_data + simm;
            OP_B, OP_BZ: alu_out = pc + {simm[29:0], 2'b00};
            default: alu_out = '0;
        endcase
    end

    // R15 shares the single write port: PC increment, taken branch, and writeback.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state_q)
            S_FETCH: begin
                rf_we    = 1'b1;
                rf_waddr = 4'd15;
                rf_wdata = pc + 32'd4;
            end
            S_EXEC: begin
                rf_we    = is_branch && branch_taken;
                rf_waddr = 4'd15;
                rf_wdata = alu_out;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = ir_q[27:24];
                rf_wdata = is_load ? mdr_q : alu_q;
            end
            default: rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            ir_q    <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_FETCH;
                S_FETCH: begin
                    ir_q    <= mem_rdata;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_NOP)       state_q <= S_FETCH;
                    else if (op == OP_HALT) state_q <= S_HALT;
                    else                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    alu_q <= alu_out;
                    if (is_branch) state_q <= S_FETCH;
                    else if (is_load || (op == OP_STR) || (op == OP_STRB)) state_q <= S_MEM;
                    else state_q <= S_WB;
                end
                S_MEM: begin
                    if (is_load) begin
                        mdr_q   <= (op == OP_LDR) ? mem_rdata : {24'd0, mem_rdata[31:24]};
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_data_path.sv
// Scoreboard bench: an instruction-level reference model predicts each retirement;
// a negedge monitor compares state sequence, alu_out in EXEC, and registers at each FETCH/HALT entry.

module tb_risc_data_path;
    logic       main_clk = 1'b0;
    logic       reset;
    logic [9:0] current_state;

    risc_data_path dut (
        .main_clk      (main_clk),
        .reset         (reset),
        .current_state (current_state)
    );

    always #5 main_clk = ~main_clk;

    typedef struct packed {
        logic              halt;
        logic              last;
        logic              chk_seq;
        logic              chk_alu;
        logic [31:0]       seq;
        logic [31:0]       alu;
        logic [15:0][31:0] regs;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog_q[$];
    logic [7:0]  m_mem [512];
    logic [31:0] m_reg [16];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic logic [31:0] m_word(input logic [31:0] a);
        int unsigned b = a % 512;
        return {m_mem[b], m_mem[(b + 1) % 512], m_mem[(b + 2) % 512], m_mem[(b + 3) % 512]};
    endfunction

    task automatic push_rec(input bit halt, input bit last, input bit chk_seq, input bit chk_alu,
                            input logic [31:0] seq, input logic [31:0] alu);
        exp_t e;
        e.halt = halt; e.last = last; e.chk_seq = chk_seq; e.chk_alu = chk_alu;
        e.seq = seq; e.alu = alu;
        for (int i = 0; i < 16; i++) e.regs[i] = m_reg[i];
        exp_q.push_back(e);
    endtask

    task automatic model_run(input int max_steps, output bit halted);
        halted = 0;
        push_rec(0, max_steps == 0, 0, 0, 0, 0);
        for (int s = 0; s < max_steps; s++) begin
            logic [31:0] ir, pc, a, b, d, simm, ea, res, tgt;
            int unsigned op, rd;
            bit last;
            last = (s == max_steps - 1);
            pc = m_reg[15];
            ir = m_word(pc);
            m_reg[15] = pc + 4;
            op = ir[31:28];
            rd = ir[27:24];
            a = m_reg[ir[23:20]];
            b = m_reg[ir[19:16]];
            d = m_reg[rd];
            simm = {{16{ir[15]}}, ir[15:0]};
            ea = a + simm;
            case (op)
                0: push_rec(0, last, 1, 0, 32'h12, 0);
                1, 2, 3, 4, 5, 6, 7, 8: begin
                    case (op)
                        1: res = a + b;
                        2: res = a - b;
                        3: res = a & b;
                        4: res = a | b;
                        5: res = a ^ b;
                        6: res = b;
                        7: res = {16'd0, ir[15:0]};
                        default: res = a + simm;
                    endcase
                    m_reg[rd] = res;
                    push_rec(0, last, 1, 1, 32'h1235, res);
                end
                9: begin
                    m_reg[rd] = m_word(ea);
                    push_rec(0, last, 1, 1, 32'h12345, ea);
                end
                11: begin
                    m_reg[rd] = {24'd0, m_mem[ea % 512]};
                    push_rec(0, last, 1, 1, 32'h12345, ea);
                end
                10: begin
                    for (int k = 0; k < 4; k++) m_mem[(ea + k) % 512] = d[31 - 8 * k -: 8];
                    push_rec(0, last, 1, 1, 32'h1234, ea);
                end
                12: begin
                    m_mem[ea % 512] = d[7:0];
                    push_rec(0, last, 1, 1, 32'h1234, ea);
                end
                13, 14: begin
                    tgt = m_reg[15] + (simm << 2);
                    if (op == 13 || d == 0) m_reg[15] = tgt;
                    push_rec(0, last, 1, 1, 32'h123, tgt);
                end
                default: begin
                    push_rec(1, 1, 1, 0, 32'h12, 0);
                    halted = 1;
                    return;
                end
            endcase
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] seq, alu_seen;
        logic [9:0]  prev;
        exp_t        e;
        seq = 0; alu_seen = 0; prev = 0;
        forever begin
            @(negedge main_clk);
            if (!reset) begin
                seq = 0;
                prev = 0;
            end else begin
                if (current_state == 10'd3) alu_seen = dut.alu_out;
                if (current_state == 10'd1 || (current_state == 10'd6 && prev != 10'd6)) begin
                    if (mon_en) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_event: got state %0d with no expectation pending", current_state);
                            mon_en = 0;
                        end else begin
                            e = exp_q.pop_front();
                            chk("event_state", 32'(current_state), e.halt ? 32'd6 : 32'd1);
                            if (e.chk_seq) chk("state_seq", seq, e.seq);
                            if (e.chk_alu) chk("alu_out_exec", alu_seen, e.alu);
                            for (int i = 0; i < 16; i++)
                                chk($sformatf("R%0d", i), dut.register_file.reg_to_mult[i], e.regs[i]);
                            if (e.last) mon_en = 0;
                        end
                    end
                    seq = 32'h1;
                end else begin
                    seq = (seq << 4) | 32'(current_state);
                end
                prev = current_state;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic begin_reset();
        @(negedge main_clk);
        reset = 1'b0;
        #1;
        chk("reset_state", 32'(current_state), 32'd0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("reset_R%0d", i), dut.register_file.reg_to_mult[i], 32'd0);
    endtask

    task automatic release_reset();
        #5;
        reset = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < 512; i++) m_mem[i] = 8'($urandom);
        for (int k = 0; k < prog_q.size(); k++)
            for (int j = 0; j < 4; j++) m_mem[4 * k + j] = prog_q[k][31 - 8 * j -: 8];
        for (int i = 0; i < 512; i++) dut.ram.memory[i] = m_mem[i];
        for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
    endtask

    task automatic poke(input int addr, input logic [7:0] v);
        m_mem[addr] = v;
        dut.ram.memory[addr] = v;
    endtask

    task automatic run(input int max_steps);
        bit halted;
        int n, diffs;
        exp_q.delete();
        model_run(max_steps, halted);
        mon_en = 1;
        release_reset();
        n = 0;
        while (mon_en && n < 5000) begin
            @(negedge main_clk);
            n++;
        end
        chk("run_completed", {31'd0, mon_en}, 32'd0);
        mon_en = 0;
        if (halted) begin
            repeat (5) @(negedge main_clk);
            chk("halt_hold_state", 32'(current_state), 32'd6);
            for (int i = 0; i < 16; i++)
                chk($sformatf("halt_frozen_R%0d", i), dut.register_file.reg_to_mult[i], m_reg[i]);
        end
        diffs = 0;
        for (int i = 0; i < 512; i++) if (dut.ram.memory[i] !== m_mem[i]) diffs++;
        chk("ram_contents", diffs, 0);
        begin_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned k = $urandom_range(0, 99);
        logic [3:0]  op, rd, rn, rm;
        logic [15:0] imm;
        rd = 4'($urandom_range(0, 13));
        rn = 4'($urandom_range(0, 15));
        rm = 4'($urandom_range(0, 15));
        imm = 16'($urandom);
        if (k < 35) begin
            op = 4'($urandom_range(1, 8));
        end else if (k < 50) begin
            op = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd11;
        end else if (k < 65) begin
            // R14 is never written by random code, so stores land in 256..511 (wrapping into bytes 0..2).
            op  = ($urandom_range(0, 1) == 0) ? 4'd10 : 4'd12;
            rd  = 4'($urandom_range(0, 15));
            rn  = 4'd14;
            imm = 16'($urandom_range(256, 511));
        end else if (k < 80) begin
            op  = ($urandom_range(0, 1) == 0) ? 4'd13 : 4'd14;
            rd  = 4'($urandom_range(0, 15));
            imm = 16'($urandom_range(0, 3));
        end else begin
            op = 4'd0;
        end
        return {op, rd, rn, rm, imm};
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        begin_reset();

        prog_q = {32'h71000005, 32'hF0000000};
        preload(); run(50);

        prog_q = {32'hB5000035, 32'h95000032, 32'hF0000000};
        preload(); poke(50, 8'h00); poke(51, 8'h00); poke(52, 8'h00); poke(53, 8'h05); run(50);

        prog_q = {32'h71000005, 32'h12110000, 32'hA2000030, 32'hF0000000};
        preload(); run(50);

        prog_q = {32'h71000005, 32'h23010000, 32'h84300005, 32'hF0000000};
        preload(); run(50);

        prog_q = {32'hE0000001, 32'h71000007, 32'hF0000000};
        preload(); run(50);

        prog_q = {32'h70000001, 32'hE0000001, 32'h72000009, 32'hF0000000};
        preload(); run(50);

        prog_q = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'hD000FFFF};
        preload(); run(10);

        prog_q = {32'h9FE00040, 32'h71000001, 32'h72000002, 32'h73000003, 32'h74000004,
                  32'h75000005, 32'h76000006, 32'h77000007, 32'hF0000000};
        preload(); poke(64, 8'h00); poke(65, 8'h00); poke(66, 8'h00); poke(67, 8'h20); run(50);

        for (int t = 0; t < 30; t++) begin
            prog_q.delete();
            for (int i = 0; i < 16; i++) prog_q.push_back(rand_instr());
            for (int i = 0; i < 4; i++) prog_q.push_back(32'hF0000000);
            preload();
            run(200);
        end

        // Reset during a store's MEM state aborts it; a full run commits it.
        prog_q = {32'h71000077, 32'hC1E0012C, 32'hF0000000};
        preload(); poke(300, 8'h00);
        release_reset();
        n = 0;
        while (current_state != 10'd4 && n < 50) begin
            @(negedge main_clk);
            n++;
        end
        chk("reached_mem", 32'(current_state), 32'd4);
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(current_state), 32'd0);
        chk("abort_R1", dut.register_file.reg_to_mult[1], 32'd0);
        chk("abort_pc", dut.register_file.reg_to_mult[15], 32'd0);
        repeat (2) @(negedge main_clk);
        chk("aborted_store_ram", 32'(dut.ram.memory[300]), 32'd0);
        #1;
        release_reset();
        n = 0;
        while (current_state != 10'd6 && n < 50) begin
            @(negedge main_clk);
            n++;
        end
        chk("store_run_halted", 32'(current_state), 32'd6);
        chk("completed_store_ram", 32'(dut.ram.memory[300]), 32'h77);
        begin_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
